// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, optional parity, 1 or 2
// stop bits, framing/break detection and a one-cycle completion pulse.
module uart_rx_cfg #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_busy
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int H     = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(PAYLOAD_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_A    = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_B    = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (CPB < 8) begin : g_cpb_check
    $error("uart_rx_cfg: CLK_HZ/BIT_RATE must be at least 8");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9) begin : g_payload_check
    $error("uart_rx_cfg: PAYLOAD_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                  state;
  logic                    rx_meta, rxs, rxs_q;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    stop_idx;
  logic                    stop0_bad;
  logic                    samp_a, samp_b;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    par_bit;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic vote, bit_end, at_dec, pbit_eff, first_stop_zero, frame_bad;
  assign vote            = majority3(samp_a, samp_b, rxs);
  assign bit_end         = (cnt == CNT_LAST);
  assign at_dec          = (cnt == CNT_DEC);
  assign pbit_eff        = (PARITY_EN != 0) ? par_bit : 1'b0;
  assign first_stop_zero = (stop_idx == 1'b0) ? ~vote : stop0_bad;
  assign frame_bad       = stop0_bad | ~vote;
  assign uart_rx_busy    = (state != IDLE);

  // Synchroniser; rxs_q gives the falling-edge reference for start detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt == CNT_A) samp_a <= rxs;
    if (cnt == CNT_B) samp_b <= rxs;
    if (state == DATA && at_dec) shreg <= {vote, shreg[PAYLOAD_BITS-1:1]};
    if (state == PARITY && at_dec) par_bit <= vote;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      cnt                <= '0;
      idx                <= '0;
      stop_idx           <= 1'b0;
      stop0_bad          <= 1'b0;
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
    end else begin
      uart_rx_valid <= 1'b0;
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
      if (!uart_rx_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rxs_q && !rxs) begin
            state <= START;
            cnt   <= '0;
          end
          START: begin
            if (at_dec && vote) begin
              state <= IDLE;
            end else if (bit_end) begin
              state <= DATA;
              idx   <= '0;
            end
          end
          DATA: if (bit_end) begin
            if (idx == IDX_LAST) begin
              state    <= (PARITY_EN != 0) ? PARITY : STOP;
              stop_idx <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          PARITY: if (bit_end) state <= STOP;
          // Frame completes at the last stop-bit decision, not at its end
          STOP: begin
            if (at_dec) begin
              if (stop_idx == STOP_LAST) begin
                uart_rx_valid      <= 1'b1;
                uart_rx_data       <= shreg;
                uart_rx_parity_err <= (PARITY_EN != 0) &&
                                      ((^shreg ^ pbit_eff) != 1'(PARITY_ODD));
                uart_rx_frame_err  <= frame_bad;
                uart_rx_break      <= (shreg == '0) && !pbit_eff && first_stop_zero;
                state              <= frame_bad ? WAIT_HIGH : IDLE;
              end else begin
                stop0_bad <= ~vote;
              end
            end else if (bit_end) begin
              stop_idx <= 1'b1;
            end
          end
          WAIT_HIGH: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) share one serial
// driver; expected results are derived from the transmitted frame contents.
module tb_uart_rx_cfg;

  localparam int CPB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, en, line;
  int   sel;
  logic rxd [3];
  logic vld [3];
  logic [7:0] dat [3];
  logic perr [3];
  logic ferr [3];
  logic brk [3];
  logic busy [3];

  assign rxd[0] = (sel == 0) ? line : 1'b1;
  assign rxd[1] = (sel == 1) ? line : 1'b1;
  assign rxd[2] = (sel == 2) ? line : 1'b1;

  uart_rx_cfg #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_n1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]), .uart_rx_en(en),
    .uart_rx_valid(vld[0]), .uart_rx_data(dat[0]), .uart_rx_parity_err(perr[0]),
    .uart_rx_frame_err(ferr[0]), .uart_rx_break(brk[0]), .uart_rx_busy(busy[0]));

  uart_rx_cfg #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_e1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]), .uart_rx_en(en),
    .uart_rx_valid(vld[1]), .uart_rx_data(dat[1]), .uart_rx_parity_err(perr[1]),
    .uart_rx_frame_err(ferr[1]), .uart_rx_break(brk[1]), .uart_rx_busy(busy[1]));

  uart_rx_cfg #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) dut_n2 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[2]), .uart_rx_en(en),
    .uart_rx_valid(vld[2]), .uart_rx_data(dat[2]), .uart_rx_parity_err(perr[2]),
    .uart_rx_frame_err(ferr[2]), .uart_rx_break(brk[2]), .uart_rx_busy(busy[2]));

  int vcnt [3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (vld[k] === 1'b1) vcnt[k]++;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b, input int nbits);
    line = b;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // Sends one frame to instance k and checks the result against the frame rules
  task automatic run_frame(input string tag, input int k, input logic [7:0] d,
                           input logic pb, input logic s0, input logic s1,
                           input int hold_low);
    int   base;
    logic e_perr, e_ferr, e_brk;
    base = vcnt[k];
    sel  = k;
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(d[i], 1);
    if (k == 1) bit_time(pb, 1);
    bit_time(s0, 1);
    if (k == 2) bit_time(s1, 1);
    if (hold_low > 0) begin
      bit_time(1'b0, hold_low);
      check_eq({tag, "_waithigh_busy"}, int'(busy[k]), 1);
      check_eq({tag, "_hold_count"}, vcnt[k] - base, 1);
    end
    bit_time(1'b1, 3);
    e_perr = (k == 1) && ((^d ^ pb) != 1'b0);
    e_ferr = !s0 || (k == 2 && !s1);
    e_brk  = (d == 8'h00) && (k != 1 || !pb) && !s0;
    check_eq({tag, "_valid_count"}, vcnt[k] - base, 1);
    check_eq({tag, "_data"}, int'(dat[k]), int'(d));
    check_eq({tag, "_parity_err"}, int'(perr[k]), int'(e_perr));
    check_eq({tag, "_frame_err"}, int'(ferr[k]), int'(e_ferr));
    check_eq({tag, "_break"}, int'(brk[k]), int'(e_brk));
    check_eq({tag, "_busy_after"}, int'(busy[k]), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(vld[0]), 0);
    check_eq({tag, "_data"}, int'(dat[0]), 0);
    check_eq({tag, "_frame_err"}, int'(ferr[0]), 0);
    check_eq({tag, "_break"}, int'(brk[0]), 0);
    check_eq({tag, "_busy"}, int'(busy[0]), 0);
  endtask

  initial begin
    int base;
    resetn = 1'b0;
    en     = 1'b1;
    line   = 1'b1;
    sel    = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    resetn = 1'b1;
    bit_time(1'b1, 2);

    run_frame("a5", 0, 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    run_frame("par_bad", 1, 8'h03, 1'b1, 1'b1, 1'b1, 0);
    run_frame("par_ok", 1, 8'h03, 1'b0, 1'b1, 1'b1, 0);
    run_frame("stop0", 0, 8'h55, 1'b0, 1'b0, 1'b1, 3);
    run_frame("after_stop0", 0, 8'h12, 1'b0, 1'b1, 1'b1, 0);
    run_frame("brk", 0, 8'h00, 1'b0, 1'b0, 1'b1, 10);
    run_frame("after_brk", 0, 8'h5A, 1'b0, 1'b1, 1'b1, 0);

    // Two-cycle glitch on the line must be rejected as a false start
    sel  = 0;
    base = vcnt[0];
    line = 1'b0;
    repeat (2) @(negedge clk);
    line = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("glitch_busy_start", int'(busy[0]), 1);
    repeat (8) @(negedge clk);
    check_eq("glitch_busy_end", int'(busy[0]), 0);
    bit_time(1'b1, 2);
    check_eq("glitch_no_valid", vcnt[0] - base, 0);

    run_frame("s2_bad", 2, 8'h81, 1'b0, 1'b1, 1'b0, 0);
    run_frame("s2_ok", 2, 8'hC3, 1'b0, 1'b1, 1'b1, 0);

    // Reset in the middle of a 0xFF frame
    sel  = 0;
    base = vcnt[0];
    bit_time(1'b0, 1);
    bit_time(1'b1, 3);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bit_time(1'b1, 8);
    check_eq("mid_rst_no_valid", vcnt[0] - base, 0);
    run_frame("rst_3c", 0, 8'h3C, 1'b0, 1'b1, 1'b1, 0);

    // Enable dropped in the middle of a 0xFF frame
    base = vcnt[0];
    bit_time(1'b0, 1);
    bit_time(1'b1, 3);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("en_drop_busy", int'(busy[0]), 0);
    en = 1'b1;
    bit_time(1'b1, 8);
    check_eq("en_drop_no_valid", vcnt[0] - base, 0);
    run_frame("en_3c", 0, 8'h3C, 1'b0, 1'b1, 1'b1, 0);

    for (int i = 0; i < 10; i++) begin
      int         k;
      logic [7:0] d;
      logic       pb, s0, s1;
      k  = int'($urandom_range(0, 2));
      d  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pb = 1'($urandom);
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", i), k, d, pb, s0, s1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600: line bit rate in bits/s.
REQ-003 Parameter PAYLOAD_BITS, default 8: data bits per frame, legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 Parameter PARITY_EN, default 0: 1 = a parity bit follows the data bits.
REQ-006 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 resetn  input  1  reset, asynchronous, active-low.
REQ-009 uart_rxd  input  1  asynchronous serial line, idle high.
REQ-010 uart_rx_en  input  1  receive enable.
REQ-011 uart_rx_valid  output  1  one-cycle pulse, frame complete.
REQ-012 uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB received first.
REQ-013 uart_rx_parity_err  output  1  parity mismatch on last frame.
REQ-014 uart_rx_frame_err  output  1  first or second stop bit sampled 0 on last frame.
REQ-015 uart_rx_break  output  1  last frame was a break condition.
REQ-016 uart_rx_busy  output  1  high in any state other than IDLE.

Function
REQ-017 CPB = CLK_HZ/BIT_RATE (integer division), H = CPB/2; elaboration SHALL fail if CPB < 8.
REQ-018 uart_rxd SHALL pass through a 2-flop synchroniser reset to 1; all logic SHALL use the synchronised value (rxs).
REQ-019 The bit counter SHALL count 0..CPB-1 and wrap at CPB-1; it SHALL be cleared on entry to START.
REQ-020 Each bit value SHALL be the majority of rxs at counts H-1, H and H+1; the decision point is count H+1.
REQ-021 States SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-022 IDLE->START when rxs=0 and uart_rx_en=1.
REQ-023 START->IDLE at the decision point if the majority is 1 (false start; no valid pulse).
REQ-024 START->DATA at count CPB-1.
REQ-025 DATA SHALL shift in PAYLOAD_BITS bits LSB first, advancing each bit at count CPB-1.
REQ-026 After the last data bit, DATA SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-027 PARITY SHALL sample one bit, then go to STOP at count CPB-1.
REQ-028 STOP SHALL sample STOP_BITS bits.
REQ-029 At the decision point of the last stop bit, STOP SHALL go to IDLE if no stop bit was 0, else to WAIT_HIGH; no wait for the end of the bit.
REQ-030 uart_rx_valid SHALL pulse exactly one cycle, the cycle after the decision point of the last stop bit.
REQ-031 uart_rx_data and the error flags SHALL update in the same cycle as that pulse and hold until the next pulse.
REQ-032 parity_err = 1 iff PARITY_EN=1 and XOR(data bits, parity bit) != PARITY_ODD.
REQ-033 break = 1 iff all data bits, the parity bit (if enabled) and the first stop bit are 0; frame_err SHALL also be 1 in that case.
REQ-034 WAIT_HIGH->IDLE when rxs=1; a line held low SHALL produce no further frames.
REQ-035 If uart_rx_en=0 in any state, the FSM SHALL go to IDLE at the next edge with no valid pulse; the synchroniser keeps running.
REQ-036 Counter widths SHALL be sized from CPB and PAYLOAD_BITS without overflow.

Reset
REQ-037 On resetn low, immediately (asynchronously): state IDLE, synchroniser = 1, valid/parity_err/frame_err/break/busy = 0, data = 0.
REQ-038 On release of reset, reception SHALL start only at a falling edge of rxs; a frame in progress at reset is discarded.

Verification
(All scenarios use CLK_HZ=1000000, BIT_RATE=100000, i.e. CPB=10, H=5, unless stated.)
REQ-039 8N1, send 0xA5 -> exactly one valid pulse; data=0xA5; parity_err=frame_err=break=0; busy low after the pulse.
REQ-040 PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> valid, data=0x03, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-041 Send 0x55 with stop bit 0, hold low 3 bit times, then idle and send 0x12 -> first valid with frame_err=1 and break=0; one wait in WAIT_HIGH; second valid with data=0x12 and frame_err=0.
REQ-042 Line low for 20 bit times -> exactly one valid with data=0x00, break=1, frame_err=1; none further until the line goes high and a new frame arrives.
REQ-043 rxd low pulse of 2 cycles -> no valid; busy deasserts by the START decision point; STOP_BITS=2 with the second stop bit 0 -> frame_err=1.
REQ-044 resetn asserted, or uart_rx_en dropped, mid-DATA of 0xFF -> no valid; outputs at reset values (reset case); next full frame 0x3C received correctly.
